// File: rtl/npu_seq.sv
// Sequencer for the NPU element-wise datapath: latches a job on START, streams operand
// reads one element per cycle, tracks result writes through a valid pipe and pulses FINISH.
module npu_seq #(
    parameter int ADR_W    = 10,
    parameter int PIPE_LAT = 4
) (
    input  logic             CLK,
    input  logic             RESET_X,
    input  logic             SOFT_RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [1:0]       ASEL,
    input  logic [1:0]       BSEL,
    input  logic [1:0]       CSEL,
    input  logic [ADR_W-1:0] M1POS,
    input  logic [ADR_W-1:0] M2POS,
    input  logic [ADR_W-1:0] M3POS,
    input  logic [ADR_W-1:0] M1SIZE,
    input  logic [ADR_W-1:0] M2SIZE,
    input  logic [ADR_W-1:0] M3SIZE,
    output logic [ADR_W-1:0] RADR_A,
    output logic [ADR_W-1:0] RADR_B,
    output logic             RD_A,
    output logic             RD_B,
    output logic             DP_VALID,
    output logic [ADR_W-1:0] WADR_C,
    output logic             WE_C,
    output logic             BUSY,
    output logic             FINISH,
    output logic             ERR,
    output logic [2:0]       fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_RQT = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;
    localparam logic [ADR_W-1:0] ONE = 1;

    logic [2:0]          state;
    logic [1:0]          op_q;
    logic [1:0]          asel_q;
    logic [1:0]          bsel_q;
    logic [1:0]          csel_q;
    logic [ADR_W-1:0]    pa;
    logic [ADR_W-1:0]    pb;
    logic [ADR_W-1:0]    pc;
    logic [ADR_W-1:0]    n_q;
    logic [ADR_W-1:0]    idx;
    logic [ADR_W-1:0]    wr_cnt;
    logic [ADR_W-1:0]    last_idx;
    logic [ADR_W-1:0]    radr_a_q;
    logic [ADR_W-1:0]    radr_b_q;
    logic                rd_a_q;
    logic                rd_b_q;
    logic                dp_valid_q;
    logic                err_q;
    logic [PIPE_LAT-1:0] vld_pipe;
    logic                we_c;
    logic                use_b;

    // Memory select 0 is the constant source; its base and size read as zero.
    function automatic logic [ADR_W-1:0] pick(
        input logic [1:0]       sel,
        input logic [ADR_W-1:0] v1,
        input logic [ADR_W-1:0] v2,
        input logic [ADR_W-1:0] v3
    );
        case (sel)
            2'd1:    pick = v1;
            2'd2:    pick = v2;
            2'd3:    pick = v3;
            default: pick = '0;
        endcase
    endfunction

    assign last_idx = n_q - ONE;
    assign we_c     = vld_pipe[PIPE_LAT-1];
    assign use_b    = (bsel_q != 2'd0) && (op_q != OP_RQT);

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state      <= S_IDLE;
            op_q       <= '0;
            asel_q     <= '0;
            bsel_q     <= '0;
            csel_q     <= '0;
            pa         <= '0;
            pb         <= '0;
            pc         <= '0;
            n_q        <= '0;
            idx        <= '0;
            wr_cnt     <= '0;
            radr_a_q   <= '0;
            radr_b_q   <= '0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            err_q      <= 1'b0;
            vld_pipe   <= '0;
        end else if (SOFT_RESET) begin
            // Abort drops everything in flight but keeps the sticky error of the last job.
            state      <= S_IDLE;
            op_q       <= '0;
            asel_q     <= '0;
            bsel_q     <= '0;
            csel_q     <= '0;
            pa         <= '0;
            pb         <= '0;
            pc         <= '0;
            n_q        <= '0;
            idx        <= '0;
            wr_cnt     <= '0;
            radr_a_q   <= '0;
            radr_b_q   <= '0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            vld_pipe[0] <= dp_valid_q;
            for (int k = 1; k < PIPE_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            if (we_c) begin
                wr_cnt <= wr_cnt + ONE;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_q   <= OP;
                        asel_q <= ASEL;
                        bsel_q <= BSEL;
                        csel_q <= CSEL;
                        pa     <= pick(ASEL, M1POS, M2POS, M3POS);
                        pb     <= pick(BSEL, M1POS, M2POS, M3POS);
                        pc     <= pick(CSEL, M1POS, M2POS, M3POS);
                        n_q    <= pick(CSEL, M1SIZE, M2SIZE, M3SIZE);
                        idx    <= '0;
                        wr_cnt <= '0;
                        err_q  <= 1'b0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (csel_q == 2'd0 || n_q == '0 || op_q == OP_RSV) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        // Element 0 is presented in the first RUN cycle.
                        dp_valid_q <= 1'b1;
                        rd_a_q     <= (asel_q != 2'd0);
                        rd_b_q     <= use_b;
                        radr_a_q   <= pa;
                        radr_b_q   <= pb;
                        idx        <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx == last_idx) begin
                        dp_valid_q <= 1'b0;
                        rd_a_q     <= 1'b0;
                        rd_b_q     <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        idx      <= idx + ONE;
                        radr_a_q <= pa + idx + ONE;
                        radr_b_q <= pb + idx + ONE;
                    end
                end
                S_DRAIN: begin
                    // Leave on the final write so FINISH follows it directly.
                    if (we_c && wr_cnt == last_idx) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign RADR_A    = radr_a_q;
    assign RADR_B    = radr_b_q;
    assign RD_A      = rd_a_q;
    assign RD_B      = rd_b_q;
    assign DP_VALID  = dp_valid_q;
    assign WADR_C    = pc + wr_cnt;
    assign WE_C      = we_c;
    assign BUSY      = (state == S_CHECK) || (state == S_RUN) || (state == S_DRAIN);
    assign FINISH    = (state == S_DONE);
    assign ERR       = err_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_npu_seq.sv
// Directed bench for npu_seq: each job is traced cycle by cycle from START and the
// captured strobes, addresses and FINISH timing are compared against hand-derived values.
module tb_npu_seq;

    localparam int ADR_W    = 10;
    localparam int PIPE_LAT = 4;

    typedef logic [ADR_W-1:0] adr_q_t[$];

    logic             CLK = 1'b0;
    logic             RESET_X = 1'b0;
    logic             SOFT_RESET = 1'b0;
    logic             START = 1'b0;
    logic [1:0]       OP = '0;
    logic [1:0]       ASEL = '0;
    logic [1:0]       BSEL = '0;
    logic [1:0]       CSEL = '0;
    logic [ADR_W-1:0] M1POS = '0, M2POS = '0, M3POS = '0;
    logic [ADR_W-1:0] M1SIZE = '0, M2SIZE = '0, M3SIZE = '0;
    logic [ADR_W-1:0] RADR_A, RADR_B, WADR_C;
    logic             RD_A, RD_B, DP_VALID, WE_C, BUSY, FINISH, ERR;
    logic [2:0]       fsm_state;

    npu_seq #(.ADR_W(ADR_W), .PIPE_LAT(PIPE_LAT)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START),
        .OP(OP), .ASEL(ASEL), .BSEL(BSEL), .CSEL(CSEL),
        .M1POS(M1POS), .M2POS(M2POS), .M3POS(M3POS),
        .M1SIZE(M1SIZE), .M2SIZE(M2SIZE), .M3SIZE(M3SIZE),
        .RADR_A(RADR_A), .RADR_B(RADR_B), .RD_A(RD_A), .RD_B(RD_B),
        .DP_VALID(DP_VALID), .WADR_C(WADR_C), .WE_C(WE_C),
        .BUSY(BUSY), .FINISH(FINISH), .ERR(ERR), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // per-job trace
    adr_q_t      rda_q, rdb_q, we_q;
    logic [ADR_W-1:0] exp_q[$];
    int          rda_first, rdb_first, we_first, fin_cyc, fin_cnt, dpv_n, misalign_n;
    logic        busy_c1, err_c1, busy_fin;
    logic        busy_tr[0:31];
    logic [63:0] areset_outs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {27'd0, RD_A, RD_B, DP_VALID, WE_C, BUSY, FINISH, ERR, RADR_A, RADR_B, WADR_C};
    endfunction

    // Pulse START in cycle 0, then sample outputs in cycles 1..cycles at the falling edge.
    // Optional injections (cycle index, 0 = none) are applied after that cycle is sampled.
    task automatic run_op(input int cycles, input int restart_k, input int sreset_k, input int areset_k);
        rda_q.delete(); rdb_q.delete(); we_q.delete();
        rda_first = -1; rdb_first = -1; we_first = -1; fin_cyc = -1;
        fin_cnt = 0; dpv_n = 0; misalign_n = 0; busy_fin = 1'bx; areset_outs = '1;
        for (int i = 0; i < 32; i++) busy_tr[i] = 1'bx;
        @(negedge CLK);
        START = 1'b1;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge CLK);
            busy_tr[k] = BUSY;
            if (k == 1) begin busy_c1 = BUSY; err_c1 = ERR; end
            if (RD_A) begin if (rda_first < 0) rda_first = k; rda_q.push_back(RADR_A); end
            if (RD_B) begin if (rdb_first < 0) rdb_first = k; rdb_q.push_back(RADR_B); end
            if (WE_C) begin if (we_first < 0) we_first = k; we_q.push_back(WADR_C); end
            if (DP_VALID) dpv_n++;
            if (DP_VALID !== RD_A) misalign_n++;
            if (FINISH) begin fin_cnt++; if (fin_cyc < 0) begin fin_cyc = k; busy_fin = BUSY; end end
            START      = (k == restart_k);
            SOFT_RESET = (k == sreset_k);
            if (k == areset_k) begin
                RESET_X = 1'b0;
                #1 areset_outs = all_outs();
            end else begin
                RESET_X = 1'b1;
            end
        end
        START = 1'b0; SOFT_RESET = 1'b0; RESET_X = 1'b1;
    endtask

    // scoreboard: consecutive addresses from base, modulo 2^ADR_W
    task automatic cmp_seq(input string tag, input adr_q_t got, input logic [ADR_W-1:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + ADR_W'(i));
        check({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) check(tag, 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic set_job(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        OP = op; ASEL = a; BSEL = b; CSEL = c;
    endtask

    initial begin
        // reset
        RESET_X = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outs", all_outs(), 64'd0);
        check("reset_state", 64'(fsm_state), 64'd0);
        RESET_X = 1'b1;

        // 1: ADD, A=M1 B=M2 C=M3, four elements
        M1POS = 10'h010; M2POS = 10'h020; M3POS = 10'h030; M3SIZE = 10'd4;
        set_job(2'd0, 2'd1, 2'd2, 2'd3);
        run_op(14, 0, 0, 0);
        check("t1_busy_c1", 64'(busy_c1), 64'd1);
        check("t1_rda_first", 64'(rda_first), 64'd2);
        check("t1_rdb_first", 64'(rdb_first), 64'd2);
        cmp_seq("t1_radr_a", rda_q, 10'h010, 4);
        cmp_seq("t1_radr_b", rdb_q, 10'h020, 4);
        check("t1_dpv_n", 64'(dpv_n), 64'd4);
        check("t1_dpv_align", 64'(misalign_n), 64'd0);
        check("t1_we_first", 64'(we_first), 64'd6);
        cmp_seq("t1_wadr_c", we_q, 10'h030, 4);
        check("t1_fin_cyc", 64'(fin_cyc), 64'd10);
        check("t1_fin_cnt", 64'(fin_cnt), 64'd1);
        check("t1_busy_fin", 64'(busy_fin), 64'd0);
        check("t1_err", 64'(ERR), 64'd0);

        // 2: RQT writes back into M1, no B reads
        M1SIZE = 10'd3;
        set_job(2'd2, 2'd1, 2'd2, 2'd1);
        run_op(14, 0, 0, 0);
        check("t2_rdb_count", 64'(rdb_q.size()), 64'd0);
        cmp_seq("t2_radr_a", rda_q, 10'h010, 3);
        cmp_seq("t2_wadr_c", we_q, 10'h010, 3);
        check("t2_fin_cyc", 64'(fin_cyc), 64'd9);
        check("t2_fin_cnt", 64'(fin_cnt), 64'd1);

        // 3a: empty destination is rejected
        M1SIZE = 10'd0;
        set_job(2'd0, 2'd1, 2'd2, 2'd1);
        run_op(6, 0, 0, 0);
        check("t3a_rda_count", 64'(rda_q.size()), 64'd0);
        check("t3a_we_count", 64'(we_q.size()), 64'd0);
        check("t3a_dpv_n", 64'(dpv_n), 64'd0);
        check("t3a_fin_cyc", 64'(fin_cyc), 64'd2);
        check("t3a_fin_cnt", 64'(fin_cnt), 64'd1);
        check("t3a_err", 64'(ERR), 64'd1);

        // 3b: reserved opcode is rejected
        set_job(2'd3, 2'd1, 2'd2, 2'd3);
        run_op(6, 0, 0, 0);
        check("t3b_rd_count", 64'(rda_q.size() + rdb_q.size()), 64'd0);
        check("t3b_we_count", 64'(we_q.size()), 64'd0);
        check("t3b_fin_cyc", 64'(fin_cyc), 64'd2);
        check("t3b_err", 64'(ERR), 64'd1);

        // 3c: next accepted START clears ERR
        set_job(2'd0, 2'd1, 2'd2, 2'd3);
        run_op(14, 0, 0, 0);
        check("t3c_err_c1", 64'(err_c1), 64'd0);
        check("t3c_fin_cyc", 64'(fin_cyc), 64'd10);
        check("t3c_err_end", 64'(ERR), 64'd0);

        // 4: write address wraps 0x3FE,0x3FF,0x000,0x001; B unused
        M3POS = 10'h3FE;
        set_job(2'd1, 2'd1, 2'd0, 2'd3);
        run_op(14, 0, 0, 0);
        check("t4_rdb_count", 64'(rdb_q.size()), 64'd0);
        check("t4_wadr_2", 64'(we_q.size() > 2 ? we_q[2] : 10'h3AA), 64'h000);
        cmp_seq("t4_wadr_c", we_q, 10'h3FE, 4);
        check("t4_fin_cyc", 64'(fin_cyc), 64'd10);

        // 5a: second START during RUN is ignored
        M3POS = 10'h030;
        set_job(2'd0, 2'd1, 2'd2, 2'd3);
        run_op(16, 3, 0, 0);
        check("t5a_fin_cnt", 64'(fin_cnt), 64'd1);
        check("t5a_fin_cyc", 64'(fin_cyc), 64'd10);
        check("t5a_we_count", 64'(we_q.size()), 64'd4);

        // 5b: SOFT_RESET on the second RUN cycle aborts the job
        run_op(12, 0, 3, 0);
        check("t5b_rda_count", 64'(rda_q.size()), 64'd2);
        check("t5b_we_count", 64'(we_q.size()), 64'd0);
        check("t5b_fin_cnt", 64'(fin_cnt), 64'd0);
        check("t5b_busy_c4", 64'(busy_tr[4]), 64'd0);

        // 5c: a fresh START is accepted after the abort
        run_op(14, 0, 0, 0);
        check("t5c_fin_cyc", 64'(fin_cyc), 64'd10);
        cmp_seq("t5c_wadr_c", we_q, 10'h030, 4);

        // START together with SOFT_RESET is ignored
        @(negedge CLK);
        START = 1'b1; SOFT_RESET = 1'b1;
        @(negedge CLK);
        START = 1'b0; SOFT_RESET = 1'b0;
        check("sr_start_busy", 64'(BUSY), 64'd0);
        @(negedge CLK);
        check("sr_start_state", 64'(fsm_state), 64'd0);

        // 6: async reset during DRAIN
        run_op(16, 0, 0, 7);
        check("t6_outs_zero", areset_outs, 64'd0);
        check("t6_we_count", 64'(we_q.size()), 64'd2);
        check("t6_fin_cnt", 64'(fin_cnt), 64'd0);
        check("t6_state", 64'(fsm_state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
